// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : Byte write port into a circular FIFO, drained by an 8N1
//                serial transmitter with back-to-back frames on tx_pin.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          busy,
    output logic                          overflow,
    output logic                          tx_pin
);

    localparam int c_DIV = CLK_FREQ / BAUD;
    localparam int c_CW  = $clog2(c_DIV);
    localparam int c_AW  = $clog2(FIFO_DEPTH);

    localparam logic [c_CW-1:0] c_CNT_MAX  = c_CW'(c_DIV - 1);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);
    localparam logic [c_AW-1:0] c_PTR_ONE  = c_AW'(1);
    localparam logic [c_AW:0]   c_LVL_ONE  = (c_AW + 1)'(1);
    localparam logic [c_AW:0]   c_LVL_FULL = (c_AW + 1)'(FIFO_DEPTH);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_DATA  = 2'd2;
    localparam logic [1:0] c_ST_STOP  = 2'd3;

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_level;
    logic            r_full;
    logic            r_empty;
    logic            r_overflow;

    logic [1:0]      r_state;
    logic [c_CW-1:0] r_baud_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic            r_tx;
    logic            r_busy;

    logic            w_push;
    logic            w_pop;
    logic            w_baud_done;
    logic [c_AW:0]   w_level_next;

    assign w_push      = wr_en && !r_full;
    assign w_baud_done = (r_baud_cnt == c_CNT_MAX);
    // A pop only ever happens from the registered empty flag, so a byte
    // written into an empty FIFO is never popped in the same cycle.
    assign w_pop       = !r_empty &&
                         ((r_state == c_ST_IDLE) ||
                          ((r_state == c_ST_STOP) && w_baud_done));

    always_comb begin
        w_level_next = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_next = r_level + c_LVL_ONE;
            2'b01:   w_level_next = r_level - c_LVL_ONE;
            default: w_level_next = r_level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_level    <= w_level_next;
            r_full     <= (w_level_next == c_LVL_FULL);
            r_empty    <= (w_level_next == '0);
            r_overflow <= wr_en && r_full;
        end
    end

    // Serialiser: every state holds for c_DIV cycles; tx is registered so the
    // line value changes exactly on the edge that enters each bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_tx       <= 1'b1;
                    r_baud_cnt <= '0;
                    if (w_pop) begin
                        r_shift <= r_mem[r_rd_ptr];
                        r_state <= c_ST_START;
                        r_tx    <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                c_ST_START: begin
                    if (w_baud_done) begin
                        r_baud_cnt <= '0;
                        r_bit_idx  <= '0;
                        r_state    <= c_ST_DATA;
                        r_tx       <= r_shift[0];
                    end else begin
                        r_baud_cnt <= r_baud_cnt + c_CNT_ONE;
                    end
                end
                c_ST_DATA: begin
                    if (w_baud_done) begin
                        r_baud_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= c_ST_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + c_CNT_ONE;
                    end
                end
                c_ST_STOP: begin
                    if (w_baud_done) begin
                        r_baud_cnt <= '0;
                        // Chain straight into the next start bit when data waits.
                        if (w_pop) begin
                            r_shift <= r_mem[r_rd_ptr];
                            r_state <= c_ST_START;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= c_ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + c_CNT_ONE;
                    end
                end
                default: begin
                    r_state    <= c_ST_IDLE;
                    r_baud_cnt <= '0;
                    r_tx       <= 1'b1;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign full     = r_full;
    assign empty    = r_empty;
    assign level    = r_level;
    assign busy     = r_busy;
    assign overflow = r_overflow;
    assign tx_pin   = r_tx;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_fifo
//  Description : Randomised and directed bench for uart_tx_fifo against a
//                timing-level reference model and a serial line decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int c_DEPTH = 8;
    localparam int c_DIV   = 10;
    localparam int c_FRAME = 10 * c_DIV;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic [3:0] level;
    logic       busy;
    logic       overflow;
    logic       tx_pin;

    uart_tx_fifo #(
        .CLK_FREQ   (1000),
        .BAUD       (100),
        .FIFO_DEPTH (c_DEPTH)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .busy     (busy),
        .overflow (overflow),
        .tx_pin   (tx_pin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: FIFO contents as a queue, frame timing as plain arithmetic.
    logic [7:0] m_q[$];
    logic [7:0] line_q[$];
    logic [7:0] m_cur;
    bit         m_busy = 1'b0;
    bit         m_ovf  = 1'b0;
    int         m_fstart = 0;
    int         m_lvl;
    bit         m_pop;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_q.delete();
            line_q.delete();
            m_busy = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            m_lvl = m_q.size();
            m_pop = 1'b0;
            if (!m_busy) begin
                if (m_lvl > 0) m_pop = 1'b1;
            end else if (cyc == m_fstart + c_FRAME) begin
                if (m_lvl > 0) m_pop = 1'b1;
                else m_busy = 1'b0;
            end
            m_ovf = wr_en && (m_lvl == c_DEPTH);
            if (m_pop) begin
                m_cur    = m_q.pop_front();
                m_fstart = cyc;
                m_busy   = 1'b1;
            end
            if (wr_en && (m_lvl < c_DEPTH)) begin
                m_q.push_back(wr_data);
                line_q.push_back(wr_data);
            end
        end
    end

    int   idx;
    logic e_tx;

    always @(negedge clk) begin
        if (chk_en) begin
            if (!m_busy) begin
                e_tx = 1'b1;
            end else begin
                idx = (cyc - m_fstart) / c_DIV;
                if (idx == 0)      e_tx = 1'b0;
                else if (idx >= 9) e_tx = 1'b1;
                else               e_tx = m_cur[idx-1];
            end
            chk("level", level, m_q.size());
            chk("full", full, m_q.size() == c_DEPTH);
            chk("empty", empty, m_q.size() == 0);
            chk("busy", busy, m_busy);
            chk("overflow", overflow, m_ovf);
            chk("tx_pin", tx_pin, e_tx);
        end
    end

    // Line decoder: samples mid-bit and compares with bytes in acceptance order.
    bit         d_act = 1'b0;
    int         d_cnt = 0;
    logic [7:0] d_byte;

    always @(negedge clk) begin
        if (rst || !chk_en) begin
            d_act = 1'b0;
        end else if (!d_act) begin
            if (tx_pin == 1'b0) begin
                d_act = 1'b1;
                d_cnt = 0;
            end
        end else begin
            d_cnt++;
            if (d_cnt == 5) begin
                chk("rx_start", tx_pin, 1'b0);
            end else if (d_cnt >= 15 && d_cnt <= 85 && (d_cnt % 10) == 5) begin
                d_byte[(d_cnt - 15) / 10] = tx_pin;
            end else if (d_cnt == 95) begin
                chk("rx_stop", tx_pin, 1'b1);
                if (line_q.size() == 0) chk("rx_unexpected", line_q.size(), 1);
                else chk("rx_byte", d_byte, line_q.pop_front());
                d_act = 1'b0;
            end
        end
    end

    task automatic wr(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            done = !m_busy && (m_q.size() == 0) && (line_q.size() == 0);
        end
        if (!done) chk("drain_timeout", m_q.size() + line_q.size() + int'(m_busy), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    int gap;
    int burst;
    bit hit;

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_tx", tx_pin, 1'b1);
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_level", level, 0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single byte: start bit on the following edge, idle again 101 edges later.
        wr(8'h55);
        @(negedge clk);
        chk("single_start_tx", tx_pin, 1'b0);
        chk("single_start_busy", busy, 1'b1);
        repeat (99) @(negedge clk);
        chk("single_busy_last", busy, 1'b1);
        @(negedge clk);
        chk("single_busy_done", busy, 1'b0);
        drain();

        // Back-to-back frames.
        wr(8'hA5);
        wr(8'h3C);
        repeat (200) @(negedge clk);
        chk("b2b_busy_end", busy, 1'b0);
        drain();

        // Fill while a frame is in flight, then overflow.
        wr(8'hEE);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 8; i++) wr(8'(i));
        chk("fill_full", full, 1'b1);
        chk("fill_level", level, 8);
        wr(8'h08);
        chk("fill_ovf", overflow, 1'b1);
        chk("fill_level_keep", level, 8);
        @(negedge clk);
        chk("fill_ovf_pulse", overflow, 1'b0);

        // Write while full exactly on the STOP->START edge.
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            if (cyc == m_fstart + c_FRAME - 1) hit = 1'b1;
            else @(negedge clk);
        end
        chk("boundary_reached", hit, 1'b1);
        wr(8'h77);
        chk("boundary_ovf", overflow, 1'b1);
        chk("boundary_level", level, 7);
        drain();

        // Reset during data bit 3 with bytes queued.
        wr(8'h11);
        wr(8'h22);
        wr(8'h33);
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            if (m_busy && (cyc - m_fstart == 45)) hit = 1'b1;
            else @(negedge clk);
        end
        chk("midrst_reached", hit, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_tx", tx_pin, 1'b1);
        chk("midrst_level", level, 0);
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("midrst_quiet", tx_pin, 1'b1);
        end

        // Random traffic: idle gaps and bursts that often overrun the FIFO.
        for (int it = 0; it < 200; it++) begin
            gap   = $urandom_range(0, 60);
            burst = $urandom_range(1, 5);
            repeat (gap) @(negedge clk);
            for (int k = 0; k < burst; k++) wr(8'($urandom));
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
